column_serializer: RTL and testbench
====================================

// Module: column_serializer
// PURPOSE
//  Downstream stage of the 4x8 bit-matrix transpose. Takes one transposed
//  ROWS*COLUMNS-bit word (COLUMNS groups of ROWS bits, group i at bits
//  [i*ROWS +: ROWS]) and emits it one ROWS-bit column per beat.
//  Holds one active word and one pending word, so back-to-back words stream
//  with no bubble. Feeds the per-column bit-plane consumer of the synth.
// PARAMETERS
//  ROWS     4  bits per column beat (width of out_data)
//  COLUMNS  8  beats per word; CW = $clog2(COLUMNS), minimum 1
// PORTS
//  clk        in   1          system clock, all state updates on rising edge
//  rst        in   1          synchronous reset, active-high
//  clear      in   1          synchronous flush of both buffers
//  in_data    in   ROWS*COLS  transposed word
//  in_valid   in   1          in_data is valid
//  in_ready   out  1          stage can accept a word this cycle
//  out_data   out  ROWS       current column = active[col*ROWS +: ROWS]
//  out_col    out  CW         index of the current column
//  out_last   out  1          out_col == COLUMNS-1
//  out_valid  out  1          out_data is valid
//  out_ready  in   1          consumer takes the beat
// BEHAVIOUR
//  - Registers: active (ROWS*COLUMNS bits), pend (ROWS*COLUMNS bits),
//    act_v, pend_v, col (CW bits).
//  - Outputs are driven from these registers; no in_* to out_* comb path.
//  - out_valid = act_v, out_last = act_v & (col==COLUMNS-1),
//    out_data/out_col are taken from active/col.
//  - in_ready = !pend_v & !rst. in_accept = in_valid & in_ready.
//    out_fire = out_valid & out_ready.
//  - Reset (rst=1): act_v=0, pend_v=0, col=0, active=0, pend=0.
//    Resulting outputs: out_data=0, out_col=0, out_valid=0, out_last=0.
//    Reset overrides every other input, including during a word.
//  - clear=1 (rst=0): same register effect as reset. The input is not
//    accepted that cycle, even though in_ready=1.
//  - Invariant: pend_v implies act_v.
//  - Per cycle, with clear=0 and in priority order:
//    * out_fire & !out_last: col<=col+1.
//    * out_fire & out_last: col<=0.
//      - If pend_v: active<=pend, pend_v<=0. The next word starts the next
//        cycle with no bubble. pend_v=1 forces in_ready=0, so no accept
//        is possible this cycle.
//      - Else if in_accept: active<=in_data, act_v stays 1.
//      - Else act_v<=0.
//    * No out_fire and !act_v and in_accept: active<=in_data, act_v<=1,
//      col<=0. First beat is visible the next cycle (latency 1).
//    * No out_fire and act_v and in_accept: pend<=in_data, pend_v<=1.
//    * Otherwise all state holds.
//  - Backpressure: while out_ready=0, out_data/out_col/out_last are stable.
//  - Throughput: one column per cycle sustained. A word occupies COLUMNS
//    beats; no idle beat between consecutive words when the upstream
//    keeps the pending slot filled.
//  - col wraps only on a last-beat fire. It never exceeds COLUMNS-1,
//    including for non-power-of-2 COLUMNS.
// TESTING
//  1 Reset then in=32'h76543210 for one cycle, out_ready=1.
//    -> out_data 0,1,..,7 on cycles 1..8; out_last only with 7;
//    out_valid=0 on cycle 9.
//  2 Words 32'h76543210 and 32'hFEDCBA98 presented back-to-back,
//    out_ready=1.
//    -> 16 consecutive beats 0..F, no gap; in_ready low while pend full.
//  3 out_ready toggled 1,0,0,1 during word 1.
//    -> out_data/out_col hold on the stalled cycles; no beat lost or
//    duplicated.
//  4 Last beat fires in the same cycle a new word arrives, pend empty.
//    -> the new word's column 0 appears next cycle; pend_v stays 0.
//  5 clear asserted at col=3 with pend full.
//    -> next cycle out_valid=0, in_ready=1; a following word starts
//    at col 0.
//  6 rst pulsed mid-word with in_valid=1.
//    -> all outputs at their reset values, input not captured; normal
//    operation resumes after reset.

Source files
------------

// File: rtl/column_serializer.sv
// Column serializer: emits one ROWS-bit column per beat from a ROWS*COLUMNS-bit word.
// Double-buffered (active + pending) so back-to-back words stream without a bubble.
module column_serializer #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 8,
    localparam int CW     = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [ROWS*COLUMNS-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ROWS-1:0]         out_data,
    output logic [CW-1:0]           out_col,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS - 1);

    logic [ROWS*COLUMNS-1:0] active;
    logic [ROWS*COLUMNS-1:0] pend;
    logic                    act_v;
    logic                    pend_v;
    logic [CW-1:0]           col;

    logic in_accept;
    logic out_fire;

    assign in_ready  = !pend_v && !rst;
    assign in_accept = in_valid && in_ready;

    assign out_valid = act_v;
    assign out_last  = act_v && (col == LAST_COL);
    assign out_data  = active[col*ROWS +: ROWS];
    assign out_col   = col;
    assign out_fire  = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            active <= '0;
            pend   <= '0;
            act_v  <= 1'b0;
            pend_v <= 1'b0;
            col    <= '0;
        end else begin
            if (out_fire && out_last) begin
                col <= '0;
                // pend_v blocks in_ready, so the refill comes either from pend or from the input.
                if (pend_v) begin
                    active <= pend;
                    pend_v <= 1'b0;
                end else if (in_accept) begin
                    active <= in_data;
                end else begin
                    act_v <= 1'b0;
                end
            end else begin
                if (out_fire) begin
                    col <= col + CW'(1);
                end
                if (in_accept) begin
                    if (!act_v) begin
                        active <= in_data;
                        act_v  <= 1'b1;
                        col    <= '0;
                    end else begin
                        pend   <= in_data;
                        pend_v <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_column_serializer.sv
// Scoreboard bench for column_serializer: expected beats are queued when a word is
// accepted and popped by a negedge monitor on every output fire.
module tb_column_serializer;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 8;
    localparam int CW      = 3;

    typedef struct packed {
        logic [ROWS-1:0] data;
        logic [CW-1:0]   col;
        logic            last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic [ROWS*COLUMNS-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS-1:0]         out_data;
    logic [CW-1:0]           out_col;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    column_serializer #(.ROWS(ROWS), .COLUMNS(COLUMNS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: every beat taken must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 32'(out_data), 32'hffff_ffff);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_col",  32'(out_col),  32'(e.col));
                check("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ROWS*COLUMNS-1:0] w);
        bit done = 0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            if (in_ready) begin
                for (int i = 0; i < COLUMNS; i++) begin
                    beat_t b;
                    b.data = w[i*ROWS +: ROWS];
                    b.col  = CW'(i);
                    b.last = (i == COLUMNS - 1);
                    sb.push_back(b);
                end
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            tick();
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    logic [31:0] w1, w2, w3;

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w1 = 32'h7654_3210;
        w2 = 32'hFEDC_BA98;
        w3 = 32'h0F1E_2D3C;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_col",   32'(out_col),   32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // 1: single word, first beat one cycle after accept, idle on cycle 9
        send(w1);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data",  32'(out_data),  32'd0);
        repeat (COLUMNS) tick();
        check("t1_idle", 32'(out_valid), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: back-to-back words, no gap; in_ready low while pend is full
        send(w1);
        send(w2);
        for (int i = 0; i < 15; i++) begin
            check("t2_no_gap", 32'(out_valid), 32'd1);
            check("t2_in_ready", 32'(in_ready), 32'((2 + i) > 8));
            tick();
        end
        check("t2_idle", 32'(out_valid), 32'd0);
        wait_idle();

        // 3: stall for two cycles on beat 1
        send(w3);
        tick();
        out_ready = 1'b0;
        tick();
        check("t3_hold_col",  32'(out_col),  32'd1);
        check("t3_hold_data", 32'(out_data), 32'(w3[7:4]));
        tick();
        check("t3_hold_col2",  32'(out_col),  32'd1);
        check("t3_hold_data2", 32'(out_data), 32'(w3[7:4]));
        out_ready = 1'b1;
        wait_idle();

        // 4: new word accepted on the same cycle the last beat fires
        send(w1);
        for (int t = 0; t < 20 && out_col != CW'(COLUMNS - 1); t++) tick();
        check("t4_at_last", 32'(out_last), 32'd1);
        send(w2);
        check("t4_valid",   32'(out_valid), 32'd1);
        check("t4_col",     32'(out_col),   32'd0);
        check("t4_data",    32'(out_data),  32'(w2[3:0]));
        check("t4_no_pend", 32'(in_ready),  32'd1);
        wait_idle();

        // 5: clear at col 3 with pend full
        send(w1);
        send(w2);
        tick();
        tick();
        check("t5_col3", 32'(out_col), 32'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ready", 32'(in_ready),  32'd1);
        check("t5_col",   32'(out_col),   32'd0);
        tick();
        check("t5_still_idle", 32'(out_valid), 32'd0);
        send(w3);
        check("t5_new_col",  32'(out_col),  32'd0);
        check("t5_new_data", 32'(out_data), 32'(w3[3:0]));
        wait_idle();

        // 6: reset pulse mid-word with a word offered
        send(w1);
        tick();
        rst      = 1'b1;
        in_data  = w2;
        in_valid = 1'b1;
        #1;
        check("t6_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_data",  32'(out_data),  32'd0);
        check("t6_col",   32'(out_col),   32'd0);
        check("t6_last",  32'(out_last),  32'd0);
        tick();
        check("t6_not_captured", 32'(out_valid), 32'd0);
        send(w3);
        check("t6_resume_data", 32'(out_data), 32'(w3[3:0]));
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
